sat_up_itl_reader: RTL and testbench

//  Downstream read stage of the SAT_UP interleaver. Issues per-bit request pulses
//  to the interleaver top and collects the interleaved bits (rdata_itl qualified by

---
 rtl/sat_up_itl_reader.sv | 149 ++++++++++++++
 tb/tb_sat_up_itl_reader.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sat_up_itl_reader.sv
// SAT_UP interleaver read stage: credit-paced bit requests, QPSK pair packing, symbol FIFO.
// Optional watchdog on missing interleaver bits: define ITL_RD_TIMEOUT_EN.
module sat_up_itl_reader #(
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 12,
  parameter int TIMEOUT    = 64
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  output logic             itl_request,
  input  logic             itl_bit,
  input  logic             itl_vld,
  output logic             sym_i,
  output logic             sym_q,
  output logic             sym_vld,
  input  logic             sym_rdy,
  output logic             busy,
  output logic             frame_done,
  output logic             err
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CR_W  = ((LEN_W > CNT_W) ? LEN_W : CNT_W) + 2;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, req_cnt_q, rcv_cnt_q, outstanding;
  logic             half_q, i_hold_q, pad_q, err_q;
  logic [1:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CR_W-1:0]  credit;
  logic [1:0]       push_data;
  logic             accept, req, last_req, bit_acc, stray, push, pop, all_rcv, last_pop, flush;

  assign outstanding = req_cnt_q - rcv_cnt_q;
  // Every bit not yet popped (in flight, held as I, or inside a FIFO slot) holds a credit.
  assign credit   = CR_W'(outstanding) + CR_W'(half_q) + (CR_W'(cnt_q) << 1);
  assign accept   = (state_q == IDLE) && start && (frame_len != '0);
  assign req      = (state_q == RUN) && (req_cnt_q < len_q) && (credit < CR_W'(2 * FIFO_DEPTH));
  assign last_req = req && (req_cnt_q == len_q - LEN_W'(1));
  assign bit_acc  = itl_vld && (state_q != IDLE) && (outstanding != '0);
  assign stray    = itl_vld && !bit_acc;
  assign push     = (bit_acc && half_q) || pad_q;
  assign push_data = pad_q ? {i_hold_q, 1'b0} : {i_hold_q, itl_bit};
  assign pop      = sym_vld && sym_rdy;
  assign all_rcv  = (rcv_cnt_q == len_q) && !half_q && !pad_q;
  assign last_pop = (state_q == DRAIN) && all_rcv && (cnt_q == CNT_W'(1)) && pop && !push;

  assign itl_request = req;
  assign sym_vld     = (cnt_q != '0);
  assign sym_i       = mem_q[rd_ptr_q][1];
  assign sym_q       = mem_q[rd_ptr_q][0];
  assign busy        = (state_q != IDLE);
  assign frame_done  = last_pop;
  assign err         = err_q;

`ifdef ITL_RD_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT) + 1;
  logic [WD_W-1:0] wd_q;
  logic            wd_cond, wd_fire;

  // Fires on the TIMEOUT-th consecutive cycle of waiting for an owed bit.
  assign wd_cond = (state_q != IDLE) && (outstanding != '0) && !itl_vld;
  assign wd_fire = wd_cond && (wd_q == WD_W'(TIMEOUT - 1));
  assign flush   = wd_fire;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) wd_q <= '0;
    else        wd_q <= (wd_cond && !wd_fire) ? wd_q + 1'b1 : '0;
  end
`else
  assign flush = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)   state_d = RUN;
      RUN:     if (last_req) state_d = DRAIN;
      DRAIN:   if (last_pop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      len_q     <= '0;
      req_cnt_q <= '0;
      rcv_cnt_q <= '0;
      half_q    <= 1'b0;
      i_hold_q  <= 1'b0;
      pad_q     <= 1'b0;
      err_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 2'b00;
    end else begin
      if (accept) begin
        len_q     <= frame_len;
        req_cnt_q <= '0;
        rcv_cnt_q <= '0;
      end else begin
        if (req)     req_cnt_q <= req_cnt_q + LEN_W'(1);
        if (bit_acc) rcv_cnt_q <= rcv_cnt_q + LEN_W'(1);
      end

      if (accept || flush || pad_q) begin
        half_q <= 1'b0;
        pad_q  <= 1'b0;
      end else if (bit_acc) begin
        if (half_q) begin
          half_q <= 1'b0;
        end else begin
          half_q   <= 1'b1;
          i_hold_q <= itl_bit;
          // Odd frame: the final bit has no partner, so flag a zero-Q pad push.
          pad_q    <= (rcv_cnt_q == len_q - LEN_W'(1));
        end
      end

      if (stray || flush) err_q <= 1'b1;
      else if (accept)    err_q <= 1'b0;

      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        if (push) begin
          mem_q[wr_ptr_q] <= push_data;
          wr_ptr_q        <= wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
        cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end
endmodule

// File: tb/tb_sat_up_itl_reader.sv
// Directed bench for sat_up_itl_reader with a fixed 2-cycle-latency interleaver model.
// Timeout scenario is compiled in only with ITL_RD_TIMEOUT_EN.
module tb_sat_up_itl_reader;
  localparam int FIFO_DEPTH = 4;
  localparam int LEN_W      = 12;
  localparam int TIMEOUT    = 64;

  logic             clk = 1'b0;
  logic             n_rst = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] frame_len = '0;
  logic             itl_request, itl_bit, itl_vld;
  logic             sym_i, sym_q, sym_vld, busy, frame_done, err;
  logic             sym_rdy = 1'b0;

  sat_up_itl_reader #(.FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .frame_len(frame_len),
    .itl_request(itl_request), .itl_bit(itl_bit), .itl_vld(itl_vld),
    .sym_i(sym_i), .sym_q(sym_q), .sym_vld(sym_vld), .sym_rdy(sym_rdy),
    .busy(busy), .frame_done(frame_done), .err(err)
  );

  always #5 clk = ~clk;

  // main-side controls of the interleaver model
  logic [63:0] bits = '0;
  int gen = 0, stray_n = 0, max_bits = 1000;
  // monitor state (written only by the model/monitor process)
  int cyc = 0, reqs = 0, dones = 0, done_cyc = -1, pop_cyc = -2, last_vld_cyc = 0;
  logic [1:0] got [$];
  int checks = 0, failures = 0;

  // Monitor samples at negedge; interleaver model drives 1ns after posedge.
  initial begin
    logic [1:0] req_hist;
    int idx, last_gen, stray_done;
    req_hist = 2'b00; idx = 0; last_gen = 0; stray_done = 0;
    itl_vld = 1'b0; itl_bit = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      req_hist = {req_hist[0], itl_request};
      if (itl_request) reqs++;
      if (sym_vld && sym_rdy) begin got.push_back({sym_i, sym_q}); pop_cyc = cyc; end
      if (frame_done) begin dones++; done_cyc = cyc; end
      if (itl_vld) last_vld_cyc = cyc;
      @(posedge clk); #1;
      if (gen != last_gen) begin last_gen = gen; idx = 0; end
      itl_vld = 1'b0; itl_bit = 1'b0;
      if (!n_rst) req_hist = 2'b00;
      else if (stray_n != stray_done) begin stray_done++; itl_vld = 1'b1; itl_bit = 1'b1; end
      else if (req_hist[1] && idx < max_bits) begin
        itl_vld = 1'b1; itl_bit = bits[idx]; idx++;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout checks=%0d", checks);
    $fatal(1, "bench did not finish");
  end

  task automatic pulse_start(input int len);
    @(posedge clk); #1;
    start = 1'b1; frame_len = LEN_W'(len);
    @(posedge clk); #1;
    start = 1'b0; frame_len = '0;
  endtask

  task automatic wait_idle(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk); #1;
      if (!busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({itl_request, sym_vld, sym_i, sym_q, busy, frame_done, err} !== 7'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=0000000",
               {itl_request, sym_vld, sym_i, sym_q, busy, frame_done, err});
    end
    @(posedge clk); #1;
    n_rst = 1'b1;
  endtask

  task automatic test_even_frame();
    logic [1:0] exp [4];
    int rb, gb, db, n;
    bit ok;
    exp = '{2'b10, 2'b11, 2'b00, 2'b10};
    bits = 64'b0100_1101;  // returns 1,0,1,1,0,0,1,0
    gen++; sym_rdy = 1'b1;
    rb = reqs; gb = got.size(); db = dones;
    pulse_start(8);
    n = 1; ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (sym_vld) begin ok = 1'b1; break; end
      n++;
    end
    checks++;
    if (!ok || n != 5) begin failures++; $display("FAIL even_first_sym_latency got=%0d want=5", n); end
    wait_idle(100, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL even_idle_timeout busy=%b want=0", busy); end
    checks++;
    if (reqs - rb != 8) begin failures++; $display("FAIL even_requests got=%0d want=8", reqs - rb); end
    checks++;
    if (got.size() - gb != 4) begin failures++; $display("FAIL even_sym_count got=%0d want=4", got.size() - gb); end
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (got.size() <= gb + j || got[gb + j] !== exp[j]) begin
        failures++; $display("FAIL even_sym%0d want=%b", j, exp[j]);
      end
    end
    checks++;
    if (dones - db != 1 || done_cyc != pop_cyc) begin
      failures++; $display("FAIL even_frame_done pulses=%0d done_cyc=%0d last_pop_cyc=%0d want 1 pulse on last pop",
                           dones - db, done_cyc, pop_cyc);
    end
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL even_err got=%b want=0", err); end
  endtask

  task automatic test_odd_frame();
    logic [1:0] exp [3];
    int rb, gb, db;
    bit ok;
    exp = '{2'b11, 2'b01, 2'b10};
    bits = 64'b1_1011;  // returns 1,1,0,1,1
    gen++; sym_rdy = 1'b1;
    rb = reqs; gb = got.size(); db = dones;
    pulse_start(5);
    wait_idle(100, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL odd_idle_timeout busy=%b want=0", busy); end
    checks++;
    if (reqs - rb != 5 || got.size() - gb != 3 || dones - db != 1) begin
      failures++; $display("FAIL odd_counts reqs=%0d syms=%0d dones=%0d want 5/3/1",
                           reqs - rb, got.size() - gb, dones - db);
    end
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (got.size() <= gb + j || got[gb + j] !== exp[j]) begin
        failures++; $display("FAIL odd_sym%0d want=%b", j, exp[j]);
      end
    end
    checks++;
    if (done_cyc != pop_cyc) begin failures++; $display("FAIL odd_done_align done=%0d pop=%0d", done_cyc, pop_cyc); end
  endtask

  task automatic test_backpressure();
    int rb, gb, db, bad;
    bit ok;
    bits = 64'hC3A5_96F1;
    gen++; sym_rdy = 1'b0;
    rb = reqs; gb = got.size(); db = dones;
    pulse_start(32);
    repeat (40) @(negedge clk);
    #1;
    checks++;
    if (reqs - rb != 8) begin failures++; $display("FAIL bp_credit_requests got=%0d want=8", reqs - rb); end
    checks++;
    if (sym_vld !== 1'b1 || {sym_i, sym_q} !== 2'b10 || got.size() != gb) begin
      failures++; $display("FAIL bp_hold vld=%b sym=%b%b pops=%0d want vld=1 sym=10 pops=0",
                           sym_vld, sym_i, sym_q, got.size() - gb);
    end
    @(posedge clk); #1;
    sym_rdy = 1'b1;
    wait_idle(300, ok);
    checks++;
    if (!ok || reqs - rb != 32 || got.size() - gb != 16 || dones - db != 1) begin
      failures++; $display("FAIL bp_stream idle=%b reqs=%0d syms=%0d dones=%0d want 1/32/16/1",
                           ok, reqs - rb, got.size() - gb, dones - db);
    end
    bad = 0;
    for (int j = 0; j < 16; j++)
      if (got.size() > gb + j && got[gb + j] !== {bits[2*j], bits[2*j+1]}) bad++;
    checks++;
    if (bad != 0) begin failures++; $display("FAIL bp_sym_data wrong=%0d want=0", bad); end
  endtask

  task automatic test_err_and_zero_len();
    int gb;
    bit ok;
    stray_n++;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL stray_err err=%b busy=%b want 1/0", err, busy); end
    pulse_start(0);
    @(negedge clk); #1;
    checks++;
    if (busy !== 1'b0 || err !== 1'b1) begin failures++; $display("FAIL zero_len busy=%b err=%b want 0/1", busy, err); end
    bits = 64'b01;  // returns 1,0
    gen++; sym_rdy = 1'b1; gb = got.size();
    pulse_start(2);
    @(negedge clk); #1;
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL start_clears_err err=%b busy=%b want 0/1", err, busy); end
    wait_idle(100, ok);
    checks++;
    if (!ok || got.size() - gb != 1 || got[got.size()-1] !== 2'b10) begin
      failures++; $display("FAIL len2_frame idle=%b syms=%0d want one symbol 10", ok, got.size() - gb);
    end
  endtask

  task automatic test_reset_mid_frame();
    int rb, gb, db;
    bit ok;
    bits = 64'b0100_1101;
    gen++; sym_rdy = 1'b1;
    rb = reqs;
    pulse_start(8);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (reqs - rb >= 3) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL midrst_reach3 reqs=%0d want>=3", reqs - rb); end
    @(posedge clk); #1;
    n_rst = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ({itl_request, sym_vld, sym_i, sym_q, busy, frame_done, err} !== 7'b0) begin
      failures++; $display("FAIL midrst_outputs got=%b want=0000000",
                           {itl_request, sym_vld, sym_i, sym_q, busy, frame_done, err});
    end
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
    gen++;
    rb = reqs; gb = got.size(); db = dones;
    pulse_start(8);
    wait_idle(100, ok);
    checks++;
    if (!ok || reqs - rb != 8 || got.size() - gb != 4 || dones - db != 1 || err !== 1'b0) begin
      failures++; $display("FAIL midrst_clean_frame idle=%b reqs=%0d syms=%0d dones=%0d err=%b want 1/8/4/1/0",
                           ok, reqs - rb, got.size() - gb, dones - db, err);
    end
    checks++;
    if (got.size() < gb + 4 || {got[gb], got[gb+1], got[gb+2], got[gb+3]} !== 8'b10_11_00_10) begin
      failures++; $display("FAIL midrst_sym_data want=10110010");
    end
  endtask

`ifdef ITL_RD_TIMEOUT_EN
  task automatic test_timeout();
    int db;
    bit ok;
    bits = 64'b0100_1101;
    gen++; sym_rdy = 1'b1; max_bits = 3;
    db = dones;
    pulse_start(8);
    wait_idle(300, ok);
    // last bit lands in cycle c; TIMEOUT waiting cycles follow, IDLE shows in the next one
    checks++;
    if (!ok || cyc - last_vld_cyc != TIMEOUT + 1) begin
      failures++; $display("FAIL timeout_delay got=%0d want=%0d", cyc - last_vld_cyc, TIMEOUT + 1);
    end
    checks++;
    if (err !== 1'b1 || sym_vld !== 1'b0 || dones != db) begin
      failures++; $display("FAIL timeout_state err=%b vld=%b dones=%0d want 1/0/0", err, sym_vld, dones - db);
    end
    max_bits = 1000;
  endtask
`endif

  initial begin
    test_reset();
    test_even_frame();
    test_odd_frame();
    test_backpressure();
    test_err_and_zero_len();
    test_reset_mid_frame();
`ifdef ITL_RD_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
